// File: rtl/hft_pkg.sv
// Shared types and width helpers for the market-making pipeline blocks.
package hft_pkg;

    localparam int PRICE_WIDTH = 32;

    typedef logic [PRICE_WIDTH-1:0] price_t;
    typedef logic [PRICE_WIDTH-1:0] time_t;

    typedef enum logic {
        FILL,
        RUN
    } vol_state_e;

    // Exact accumulator width for a sum (squared=0) or sum of squares (squared=1) over 2^window_log2 words.
    function automatic int acc_width(input int data_width, input int window_log2, input bit squared);
        return squared ? (2 * data_width + window_log2) : (data_width + window_log2);
    endfunction

endpackage

// File: rtl/sample_window.sv
// Circular buffer of the most recent 2^WINDOW_LOG2 samples; exposes the entry about to be overwritten.
module sample_window
    import hft_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int WINDOW_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  vol_state_e            state,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] evicted
);

    localparam int N = 1 << WINDOW_LOG2;

    logic [DATA_WIDTH-1:0]  mem [N];
    logic [WINDOW_LOG2-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Contents are left uninitialised; entries only count once the window has been filled once.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample;
        end
    end

    assign evicted = (state == RUN) ? mem[wr_ptr] : '0;

endmodule

// File: rtl/volatility_estimator.sv
// Sliding-window population variance of mid-price samples plus a saturating sample-time index.
module volatility_estimator
    import hft_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          WINDOW_LOG2   = 4,
    parameter int unsigned TERMINAL_TIME = 10000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_mid_price,
    input  logic                  i_data_valid,
    output logic [DATA_WIDTH-1:0] o_volatility,
    output logic [DATA_WIDTH-1:0] o_curr_time,
    output logic                  o_data_valid,
    output logic                  o_window_full
);

    localparam int SUM_W  = acc_width(DATA_WIDTH, WINDOW_LOG2, 1'b0);
    localparam int SQ_W   = acc_width(DATA_WIDTH, WINDOW_LOG2, 1'b1);
    localparam int PROD_W = 2 * SUM_W;
    localparam logic [DATA_WIDTH-1:0] TIME_MAX = DATA_WIDTH'(TERMINAL_TIME);

    vol_state_e             state, state_next;
    logic [WINDOW_LOG2-1:0] fill_cnt, fill_cnt_next;

    logic [DATA_WIDTH-1:0]   evicted_p0;
    logic [2*DATA_WIDTH-1:0] new_sq_p0, old_sq_p0;

    logic [SUM_W-1:0]      sum_p1;
    logic [SQ_W-1:0]       sumsq_p1;
    logic [DATA_WIDTH-1:0] time_p1;
    logic                  vld_p1;
    logic [PROD_W-1:0]     n_sumsq_p1, sum_sq_p1, var_p1;

    function automatic logic [DATA_WIDTH-1:0] sat_vol(input logic [PROD_W-1:0] v);
        if (|v[PROD_W-1:DATA_WIDTH]) begin
            return '1;
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sat_time_inc(input logic [DATA_WIDTH-1:0] t);
        return (t >= TIME_MAX) ? TIME_MAX : t + 1'b1;
    endfunction

    sample_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .WINDOW_LOG2(WINDOW_LOG2)
    ) u_window (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .wr_en  (i_data_valid),
        .state  (state),
        .sample (i_mid_price),
        .evicted(evicted_p0)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= FILL;
            fill_cnt <= '0;
        end else begin
            state    <= state_next;
            fill_cnt <= fill_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        fill_cnt_next = fill_cnt;
        if (i_data_valid && (state == FILL)) begin
            fill_cnt_next = fill_cnt + 1'b1;
            if (fill_cnt == '1) begin
                state_next = RUN;
            end
        end
    end

    // ---- stage 0 -> 1: accumulate new sample, retire evicted one ----
    assign new_sq_p0 = {{DATA_WIDTH{1'b0}}, i_mid_price} * {{DATA_WIDTH{1'b0}}, i_mid_price};
    assign old_sq_p0 = {{DATA_WIDTH{1'b0}}, evicted_p0} * {{DATA_WIDTH{1'b0}}, evicted_p0};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_p1   <= '0;
            sumsq_p1 <= '0;
            time_p1  <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= i_data_valid;
            if (i_data_valid) begin
                sum_p1   <= sum_p1 + SUM_W'(i_mid_price) - SUM_W'(evicted_p0);
                sumsq_p1 <= sumsq_p1 + SQ_W'(new_sq_p0) - SQ_W'(old_sq_p0);
                time_p1  <= sat_time_inc(time_p1);
            end
        end
    end

    // ---- stage 1 -> 2: variance, saturation and output register ----
    assign n_sumsq_p1 = {sumsq_p1, {WINDOW_LOG2{1'b0}}};
    assign sum_sq_p1  = PROD_W'(sum_p1) * PROD_W'(sum_p1);
    assign var_p1     = (n_sumsq_p1 - sum_sq_p1) >> (2 * WINDOW_LOG2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_volatility <= '0;
            o_curr_time  <= '0;
            o_data_valid <= 1'b0;
        end else begin
            o_data_valid <= vld_p1 && (state == RUN);
            if (vld_p1 && (state == RUN)) begin
                o_volatility <= sat_vol(var_p1);
                o_curr_time  <= time_p1;
            end
        end
    end

    assign o_window_full = (state == RUN);

endmodule

// File: tb/tb_volatility_estimator.sv
// Scoreboard bench for volatility_estimator: a window model predicts each output pulse and its cycle.
module tb_volatility_estimator;

    localparam int DW = 32;
    localparam int WL = 4;
    localparam int NW = 16;
    localparam int TT = 20;

    typedef struct {
        logic [DW-1:0] vol;
        logic [DW-1:0] tm;
        int            cyc;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic [DW-1:0] i_mid_price = '0;
    logic          i_data_valid = 1'b0;
    logic [DW-1:0] o_volatility;
    logic [DW-1:0] o_curr_time;
    logic          o_data_valid;
    logic          o_window_full;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t          exp_q[$];
    logic [DW-1:0] win[$];
    logic [DW-1:0] model_time = '0;
    logic [DW-1:0] pulse_log[$];
    logic [DW-1:0] time_log[$];

    volatility_estimator #(
        .DATA_WIDTH   (DW),
        .WINDOW_LOG2  (WL),
        .TERMINAL_TIME(TT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_mid_price  (i_mid_price),
        .i_data_valid (i_data_valid),
        .o_volatility (o_volatility),
        .o_curr_time  (o_curr_time),
        .o_data_valid (o_data_valid),
        .o_window_full(o_window_full)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] model_var();
        logic [127:0] s = '0;
        logic [127:0] q = '0;
        logic [127:0] d;
        foreach (win[i]) begin
            s += 128'(win[i]);
            q += 128'(win[i]) * 128'(win[i]);
        end
        d = ((q * NW) - (s * s)) / (NW * NW);
        if (d[127:DW] != '0) return '1;
        return d[DW-1:0];
    endfunction

    always @(negedge i_clk) begin
        if (i_rst_n && o_data_valid) begin
            exp_t e;
            pulse_log.push_back(o_volatility);
            time_log.push_back(o_curr_time);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d vol=%0d time=%0d, none expected", cyc, o_volatility, o_curr_time);
            end else begin
                e = exp_q.pop_front();
                checks += 2;
                if (o_volatility !== e.vol) begin
                    errors++;
                    $display("FAIL pulse_volatility: got %0d expected %0d", o_volatility, e.vol);
                end
                if (o_curr_time !== e.tm) begin
                    errors++;
                    $display("FAIL pulse_time: got %0d expected %0d", o_curr_time, e.tm);
                end
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL pulse_latency: pulse at cycle %0d expected %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        win.delete();
        model_time = '0;
        pulse_log.delete();
        time_log.delete();
    endtask

    task automatic do_reset();
        i_data_valid = 1'b0;
        i_rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v);
        exp_t e;
        i_mid_price = v;
        i_data_valid = 1'b1;
        win.push_back(v);
        if (win.size() > NW) void'(win.pop_front());
        if (model_time < TT) model_time = model_time + 1;
        if (win.size() == NW) begin
            e.vol = model_var();
            e.tm  = model_time;
            e.cyc = cyc + 2;
            exp_q.push_back(e);
        end
        @(posedge i_clk);
        #1;
        i_data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        i_rst_n = 1'b0;
        #1;
        checks += 4;
        if (o_volatility !== '0) begin errors++; $display("FAIL reset_volatility: got %0d expected 0", o_volatility); end
        if (o_curr_time !== '0) begin errors++; $display("FAIL reset_time: got %0d expected 0", o_curr_time); end
        if (o_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_data_valid); end
        if (o_window_full !== 1'b0) begin errors++; $display("FAIL reset_window_full: got %b expected 0", o_window_full); end
        do_reset();
    endtask

    task automatic test_fill_constant();
        do_reset();
        for (int i = 0; i < NW - 1; i++) send(32'd100);
        checks++;
        if (o_window_full !== 1'b0) begin errors++; $display("FAIL fill_not_full: got %b expected 0 after 15 samples", o_window_full); end
        send(32'd100);
        checks += 2;
        if (o_window_full !== 1'b1) begin errors++; $display("FAIL fill_full_t1: got %b expected 1", o_window_full); end
        if (o_data_valid !== 1'b0) begin errors++; $display("FAIL fill_valid_t1: got %b expected 0", o_data_valid); end
        idle(3);
        checks += 4;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fill_drain: %0d pulses missing, expected 0", exp_q.size()); end
        if (pulse_log.size() != 1) begin errors++; $display("FAIL fill_pulse_count: got %0d expected 1", pulse_log.size()); end
        if (o_volatility !== 32'd0) begin errors++; $display("FAIL fill_volatility: got %0d expected 0", o_volatility); end
        if (o_curr_time !== 32'd16) begin errors++; $display("FAIL fill_time: got %0d expected 16", o_curr_time); end
    endtask

    task automatic test_alternating();
        do_reset();
        for (int i = 0; i < NW; i++) send((i % 2 == 0) ? 32'd0 : 32'd2);
        idle(3);
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL alt_drain: %0d pulses missing, expected 0", exp_q.size()); end
        if (o_volatility !== 32'd1) begin errors++; $display("FAIL alt_volatility: got %0d expected 1", o_volatility); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < NW; i++) send((i % 2 == 0) ? 32'd0 : 32'hFFFF_FFFF);
        idle(3);
        checks += 2;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sat_drain: %0d pulses missing, expected 0", exp_q.size()); end
        if (o_volatility !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_volatility: got %h expected ffffffff", o_volatility); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v8, v16;
        do_reset();
        for (int i = 0; i < NW; i++) send(32'd100);
        for (int i = 0; i < NW; i++) send(32'd104);
        idle(3);
        v8  = (pulse_log.size() > 8)  ? pulse_log[8]  : 32'hDEAD_BEEF;
        v16 = (pulse_log.size() > 16) ? pulse_log[16] : 32'hDEAD_BEEF;
        checks += 4;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d pulses missing, expected 0", exp_q.size()); end
        if (pulse_log.size() != 17) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 17", pulse_log.size()); end
        if (v8 !== 32'd4) begin errors++; $display("FAIL b2b_after8: got %0d expected 4", v8); end
        if (v16 !== 32'd0) begin errors++; $display("FAIL b2b_after16: got %0d expected 0", v16); end
    endtask

    task automatic test_time_saturation();
        logic [DW-1:0] t_first, t_last;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            send(32'd200 + 32'(i * 3));
            idle($urandom_range(0, 3));
        end
        idle(3);
        t_first = (time_log.size() > 0) ? time_log[0] : 32'hDEAD_BEEF;
        t_last  = (time_log.size() > 0) ? time_log[time_log.size()-1] : 32'hDEAD_BEEF;
        checks += 5;
        if (exp_q.size() != 0) begin errors++; $display("FAIL time_drain: %0d pulses missing, expected 0", exp_q.size()); end
        if (pulse_log.size() != 10) begin errors++; $display("FAIL time_pulse_count: got %0d expected 10", pulse_log.size()); end
        if (t_first !== 32'd16) begin errors++; $display("FAIL time_first: got %0d expected 16", t_first); end
        if (t_last !== 32'd20) begin errors++; $display("FAIL time_last: got %0d expected 20", t_last); end
        if (o_curr_time !== 32'd20) begin errors++; $display("FAIL time_hold: got %0d expected 20", o_curr_time); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 10; i++) send(32'd7 + 32'(i));
        do_reset();
        for (int i = 0; i < NW; i++) send(32'd50);
        idle(3);
        checks += 4;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain: %0d pulses missing, expected 0", exp_q.size()); end
        if (pulse_log.size() != 1) begin errors++; $display("FAIL mid_pulse_count: got %0d expected 1", pulse_log.size()); end
        if (o_volatility !== 32'd0) begin errors++; $display("FAIL mid_volatility: got %0d expected 0", o_volatility); end
        if (o_curr_time !== 32'd16) begin errors++; $display("FAIL mid_time: got %0d expected 16", o_curr_time); end
    endtask

    task automatic test_reset_async_inflight();
        do_reset();
        for (int i = 0; i < NW; i++) send((i % 2 == 0) ? 32'd0 : 32'd2);
        send(32'd2);
        checks += 3;
        if (o_data_valid !== 1'b1) begin errors++; $display("FAIL async_pre_valid: got %b expected 1", o_data_valid); end
        if (o_curr_time !== 32'd16) begin errors++; $display("FAIL async_pre_time: got %0d expected 16", o_curr_time); end
        if (o_volatility !== 32'd1) begin errors++; $display("FAIL async_pre_volatility: got %0d expected 1", o_volatility); end
        #2;
        i_rst_n = 1'b0;
        model_clear();
        #1;
        checks += 4;
        if (o_volatility !== '0) begin errors++; $display("FAIL async_volatility: got %0d expected 0", o_volatility); end
        if (o_curr_time !== '0) begin errors++; $display("FAIL async_time: got %0d expected 0", o_curr_time); end
        if (o_data_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", o_data_valid); end
        if (o_window_full !== 1'b0) begin errors++; $display("FAIL async_window_full: got %b expected 0", o_window_full); end
        repeat (2) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        idle(4);
        checks += 2;
        if (pulse_log.size() != 0) begin errors++; $display("FAIL async_dropped: got %0d pulses expected 0", pulse_log.size()); end
        if (o_window_full !== 1'b0) begin errors++; $display("FAIL async_restart_empty: got %b expected 0", o_window_full); end
    endtask

    initial begin
        test_reset();
        test_fill_constant();
        test_alternating();
        test_saturation();
        test_back_to_back();
        test_time_saturation();
        test_reset_midstream();
        test_reset_async_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/volatility_estimator.md
Name: volatility_estimator

Overview:
Upstream stage of the spread block in the market-making pipeline. It takes the stream of mid-price samples and keeps a sliding window of the most recent 2^WINDOW_LOG2 samples. For every sample it computes the population variance of that window and a saturating sample-time index. It presents both to the spread stage as volatility and current time, with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 32, width of mid-price, volatility and time words
WINDOW_LOG2, 4, log2 of window length N (N = 16)
TERMINAL_TIME, 10000, saturation ceiling for o_curr_time; must equal the spread stage's TERMINAL_TIME

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, asynchronous assert, active-low
i_mid_price  input  DATA_WIDTH  unsigned mid-price sample
i_data_valid  input  1  sample strobe; any cycle, back-to-back allowed, no backpressure
o_volatility  output  DATA_WIDTH  unsigned window variance, saturated
o_curr_time  output  DATA_WIDTH  accepted-sample count, saturating at TERMINAL_TIME
o_data_valid  output  1  single-cycle pulse qualifying o_volatility and o_curr_time
o_window_full  output  1  high once N samples have been accepted since reset

Behaviour:
- Reset: clock and reset are single clock i_clk and reset i_rst_n, asynchronous and active-low.
- While reset is asserted, every output is 0. FSM goes to FILL. Write pointer, fill count, running sum, sum-of-squares, time counter and pipeline valids all clear.
- Buffer RAM contents are not cleared. Stale entries are never used because eviction is gated by the FSM.
- Accept: a sample is accepted in any cycle with i_data_valid=1. Its value is written at wr_ptr, which then increments modulo N. The evicted value is the old entry at wr_ptr when in RUN, and 0 when in FILL.
- Stage 1 (T+1): both accumulators are updated in the same cycle:
  - sum += new - evicted
  - sumsq += new^2 - evicted^2
  - time counter = min(time + 1, TERMINAL_TIME)
- Stage 2 (T+2): compute var = (N*sumsq - sum^2) >> (2*WINDOW_LOG2), then register the outputs. o_data_valid pulses at T+2 only if the window was full after the stage-1 update.
- Fixed latency is 2 cycles. Throughput is one sample per cycle. Idle cycles (valid=0) change nothing.
- Width rules:
  - sum is DATA_WIDTH+WINDOW_LOG2 bits.
  - sumsq is 2*DATA_WIDTH+WINDOW_LOG2 bits.
  - sum^2 is 2*(DATA_WIDTH+WINDOW_LOG2) bits.
  - All arithmetic is unsigned and exact.
  - N*sumsq >= sum^2 always, so the difference is never negative.
  - A result wider than DATA_WIDTH saturates o_volatility to all ones.
- FSM:
  - FILL: fill count increments per accepted sample. On the N-th accept, go to RUN and set o_window_full at T+1.
  - RUN: stays in RUN until reset.
- o_curr_time is the time value associated with the same sample as o_volatility. It holds between pulses, and o_volatility holds too.
- Time saturation: once the counter reaches TERMINAL_TIME it stays there, so the downstream TERMINAL_TIME - time is never negative.
- Wrap-around: wr_ptr wraps from N-1 to 0 with no bubble.
- Reset mid-operation: an in-flight sample in stage 1 or 2 is dropped, with no o_data_valid pulse. The next window starts empty.

Decomposition:
- Shared package hft_pkg holds:
  - price_t and time_t (logic [DATA_WIDTH-1:0])
  - vol_state_e enum {FILL, RUN}
  - a function computing accumulator widths from DATA_WIDTH and WINDOW_LOG2
- Sub-module sample_window: N-entry circular buffer plus wr_ptr. It returns the evicted value in the write cycle, gated to 0 during FILL.
- Accumulators, FSM and the variance pipeline stay in the top level.

Test Plan:
- Reset asserted mid-cycle, asynchronously → all outputs 0 immediately, without waiting for a clock edge.
- 16 consecutive samples of 100 → no o_data_valid for samples 1-15. On sample 16: o_data_valid at T+2, o_volatility=0, o_curr_time=16; o_window_full rises at T+1.
- 16 samples alternating 0,2 → final pulse with o_volatility=1.
- After a full window of 100, feed 104 back-to-back → after 8 of them o_volatility=4; after 16 of them o_volatility=0. One pulse per cycle, no gaps.
- TERMINAL_TIME=20, 25 samples with random idle gaps → o_curr_time reads 16..20, then holds 20. Idle cycles produce no pulses.
- 10 samples, reset pulse, then 16 samples of 50 → no pulse until post-reset sample 16, then o_volatility=0 and o_curr_time=16. The pre-reset in-flight pulse is suppressed.
